// File: rtl/par2ser.sv
// par2ser: parallel-to-serial converter with a one-word holding buffer.
// Accepts WIDTH-bit words on din/din_vld/dout_rdy and emits them one bit
// per downstream handshake on dout/dout_vld/din_rdy, flagging the final
// bit of each word with dout_last. While a word shifts out, the next word
// can wait in the holding register, so a steady stream has no gaps.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   din        parallel word from upstream
//   din_vld    upstream valid
//   dout_rdy   ready to upstream (registered, ~hold_full)
//   dout       serial bit to downstream
//   dout_vld   downstream valid
//   din_rdy    downstream ready
//   dout_last  high with the final bit of each word
module par2ser #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic             dout_rdy,
    output logic             dout,
    output logic             dout_vld,
    input  logic             din_rdy,
    output logic             dout_last
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dout_rdy_q, dout_rdy_d;
    logic               dout_q, dout_d;
    logic               dout_vld_q, dout_vld_d;
    logic               dout_last_q, dout_last_d;
    logic [CNT_W-1:0]   bit_idx;

    logic wr_en;
    logic rd_en;
    logic finishing;

    assign wr_en     = din_vld & dout_rdy_q;
    assign rd_en     = (state_q == SHIFT) & din_rdy;
    assign finishing = rd_en & (cnt_q == CNT_LAST);

    // Next-state and next-output computation
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        bit_idx     = '0;

        if (finishing) begin
            cnt_d = '0;
            if (hold_full_q) begin
                // dout_rdy is low while full, so no wr_en can collide here
                word_d      = hold_q;
                hold_full_d = 1'b0;
            end else if (wr_en) begin
                word_d = din;
            end else begin
                state_d = IDLE;
            end
        end else begin
            if (rd_en) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (wr_en) begin
                if (state_q == IDLE) begin
                    word_d  = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    hold_d      = din;
                    hold_full_d = 1'b1;
                end
            end
        end

        bit_idx     = LSB_FIRST ? cnt_d : (CNT_LAST - cnt_d);
        dout_rdy_d  = ~hold_full_d;
        dout_vld_d  = (state_d == SHIFT);
        dout_d      = (state_d == SHIFT) & word_d[bit_idx];
        dout_last_d = (state_d == SHIFT) & (cnt_d == CNT_LAST);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            dout_rdy_q  <= 1'b1;
            dout_q      <= 1'b0;
            dout_vld_q  <= 1'b0;
            dout_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            dout_rdy_q  <= dout_rdy_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            dout_last_q <= dout_last_d;
        end
    end

    assign dout_rdy  = dout_rdy_q;
    assign dout      = dout_q;
    assign dout_vld  = dout_vld_q;
    assign dout_last = dout_last_q;

endmodule

// File: tb/tb_par2ser.sv
// tb_par2ser: directed bench for par2ser. Instance a is LSB-first,
// instance b is MSB-first; both WIDTH = 8.
module tb_par2ser;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] din_a;
    logic       din_vld_a, din_rdy_a;
    logic       dout_rdy_a, dout_a, dout_vld_a, dout_last_a;

    logic [7:0] din_b;
    logic       din_vld_b, din_rdy_b;
    logic       dout_rdy_b, dout_b, dout_vld_b, dout_last_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    par2ser #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .din       (din_a),
        .din_vld   (din_vld_a),
        .dout_rdy  (dout_rdy_a),
        .dout      (dout_a),
        .dout_vld  (dout_vld_a),
        .din_rdy   (din_rdy_a),
        .dout_last (dout_last_a)
    );

    par2ser #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .din       (din_b),
        .din_vld   (din_vld_b),
        .dout_rdy  (dout_rdy_b),
        .dout      (dout_b),
        .dout_vld  (dout_vld_b),
        .din_rdy   (din_rdy_b),
        .dout_last (dout_last_b)
    );

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        tick();
        tick();
        got = {dout_rdy_a, dout_vld_a, dout_a, dout_last_a};
        checks++;
        if (got !== 4'b1000) begin
            errors++;
            $display("FAIL reset_a {rdy,vld,dout,last} got=%b exp=1000", got);
        end
        got = {dout_rdy_b, dout_vld_b, dout_b, dout_last_b};
        checks++;
        if (got !== 4'b1000) begin
            errors++;
            $display("FAIL reset_b {rdy,vld,dout,last} got=%b exp=1000", got);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dout_vld_a !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle dout_vld got=%b exp=0", dout_vld_a);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq;
        logic [3:0] got, exp;
        seq = 8'b1010_0101;
        din_a = 8'hA5; din_vld_a = 1'b1; din_rdy_a = 1'b1;
        tick();
        din_vld_a = 1'b0; din_a = 8'h00;
        for (int i = 0; i < 8; i++) begin
            got = {dout_vld_a, dout_a, dout_last_a, dout_rdy_a};
            exp = {1'b1, seq[7-i], (i == 7), 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL lsb_bit%0d {vld,dout,last,rdy} got=%b exp=%b", i, got, exp);
            end
            tick();
        end
        got = {dout_vld_a, dout_a, dout_last_a, dout_rdy_a};
        checks++;
        if (got !== 4'b0001) begin
            errors++;
            $display("FAIL lsb_end {vld,dout,last,rdy} got=%b exp=0001", got);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] words [2];
        logic [7:0] seqs  [2];
        logic [7:0] seq;
        logic [3:0] got, exp;
        words[0] = 8'hA5; seqs[0] = 8'b1010_0101;
        words[1] = 8'h0F; seqs[1] = 8'b0000_1111;
        din_rdy_b = 1'b1;
        for (int w = 0; w < 2; w++) begin
            seq = seqs[w];
            din_b = words[w]; din_vld_b = 1'b1;
            tick();
            din_vld_b = 1'b0;
            for (int i = 0; i < 8; i++) begin
                got = {dout_vld_b, dout_b, dout_last_b, dout_rdy_b};
                exp = {1'b1, seq[7-i], (i == 7), 1'b1};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL msb_w%0d_bit%0d {vld,dout,last,rdy} got=%b exp=%b", w, i, got, exp);
                end
                tick();
            end
            checks++;
            if (dout_vld_b !== 1'b0) begin
                errors++;
                $display("FAIL msb_w%0d_end dout_vld got=%b exp=0", w, dout_vld_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        logic [3:0]  got, exp;
        stream = {8'b1010_0101, 8'b0011_1100};
        din_a = 8'hA5; din_vld_a = 1'b1; din_rdy_a = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            got = {dout_vld_a, dout_a, dout_last_a, dout_rdy_a};
            exp = {1'b1, stream[15-k], (k == 7 || k == 15), !(k >= 1 && k <= 7)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_bit%0d {vld,dout,last,rdy} got=%b exp=%b", k, got, exp);
            end
            if (k == 0) begin
                din_a = 8'h3C;
            end else begin
                din_vld_a = 1'b0;
            end
            tick();
        end
        got = {dout_vld_a, dout_a, dout_last_a, dout_rdy_a};
        checks++;
        if (got !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_end {vld,dout,last,rdy} got=%b exp=0001", got);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] seq;
        logic [1:0] got, exp;
        int idx, nvalid;
        seq = 8'b1010_0101;
        idx = 0; nvalid = 0;
        din_a = 8'hA5; din_vld_a = 1'b1; din_rdy_a = 1'b1;
        tick();
        din_vld_a = 1'b0;
        for (int c = 0; c < 20 && dout_vld_a === 1'b1; c++) begin
            din_rdy_a = (c >= 3 && c < 6) ? 1'b0 : 1'b1;
            nvalid++;
            got = {dout_a, dout_last_a};
            exp = {seq[7-idx], (idx == 7)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL bp_cyc%0d {dout,last} got=%b exp=%b", c, got, exp);
            end
            if (din_rdy_a) idx++;
            tick();
        end
        din_rdy_a = 1'b1;
        checks++;
        if (nvalid != 11 || idx != 8) begin
            errors++;
            $display("FAIL bp_count valid_cycles=%0d bits=%0d exp 11 and 8", nvalid, idx);
        end
    endtask

    task automatic test_finish_accept();
        logic [7:0] seq;
        logic [3:0] got, exp;
        seq = 8'b1010_0101;
        din_a = 8'hA5; din_vld_a = 1'b1; din_rdy_a = 1'b1;
        tick();
        din_vld_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got = {dout_vld_a, dout_a, dout_last_a, dout_rdy_a};
            exp = {1'b1, seq[7-i], (i == 7), 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL fa_w0_bit%0d {vld,dout,last,rdy} got=%b exp=%b", i, got, exp);
            end
            if (i == 7) begin
                din_a = 8'h0F; din_vld_a = 1'b1;
            end
            tick();
        end
        din_vld_a = 1'b0;
        seq = 8'b1111_0000;
        for (int i = 0; i < 8; i++) begin
            got = {dout_vld_a, dout_a, dout_last_a, dout_rdy_a};
            exp = {1'b1, seq[7-i], (i == 7), 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL fa_w1_bit%0d {vld,dout,last,rdy} got=%b exp=%b", i, got, exp);
            end
            tick();
        end
        checks++;
        if (dout_vld_a !== 1'b0) begin
            errors++;
            $display("FAIL fa_end dout_vld got=%b exp=0", dout_vld_a);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seq;
        logic [3:0] got, exp;
        din_a = 8'hFF; din_vld_a = 1'b1; din_rdy_a = 1'b1;
        tick();
        din_a = 8'h3C;
        tick();
        din_vld_a = 1'b0;
        tick(); tick(); tick();
        got = {dout_rdy_a, dout_vld_a, dout_a, dout_last_a};
        checks++;
        if (got !== 4'b0110) begin
            errors++;
            $display("FAIL rm_pre {rdy,vld,dout,last} got=%b exp=0110", got);
        end
        rst = 1'b1;
        #1;
        got = {dout_rdy_a, dout_vld_a, dout_a, dout_last_a};
        checks++;
        if (got !== 4'b1000) begin
            errors++;
            $display("FAIL rm_async {rdy,vld,dout,last} got=%b exp=1000", got);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (dout_vld_a !== 1'b0) begin
            errors++;
            $display("FAIL rm_stale dout_vld got=%b exp=0", dout_vld_a);
        end
        seq = 8'b1000_0000;
        din_a = 8'h01; din_vld_a = 1'b1;
        tick();
        din_vld_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got = {dout_vld_a, dout_a, dout_last_a, dout_rdy_a};
            exp = {1'b1, seq[7-i], (i == 7), 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rm_bit%0d {vld,dout,last,rdy} got=%b exp=%b", i, got, exp);
            end
            tick();
        end
        checks++;
        if (dout_vld_a !== 1'b0) begin
            errors++;
            $display("FAIL rm_end dout_vld got=%b exp=0", dout_vld_a);
        end
    endtask

    initial begin
        rst = 1'b1;
        din_a = '0; din_vld_a = 1'b0; din_rdy_a = 1'b0;
        din_b = '0; din_vld_b = 1'b0; din_rdy_b = 1'b0;
        test_reset();
        test_lsb_first();
        tick();
        test_msb_first();
        tick();
        test_back_to_back();
        tick();
        test_backpressure();
        tick();
        test_finish_accept();
        tick();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
